// File: rtl/ball_collision_detect.sv
// ---------------------------------------------------------------------------
// ball_collision_detect
//
// Event source for the point judge. Each clock takes a new sample of the ball
// centre and both blob head centres. The block reports three kinds of contact
// event: ball touches player 1, ball touches player 2, and ball reaches the
// ground line. Each event is a single-cycle pulse per contact. A contact that
// is held over many frames gives one pulse, so the judge's touch counters
// advance once per touch.
//
// Three-stage pipeline, latency 3 clk from input sample to output:
//   S1  signed deltas dx/dy per player, ground compare on ball bottom
//   S2  squared distance dx*dx + dy*dy (27-bit, exact)
//   S3  radius compare, edge detect, holdoff and ground re-arm, registered outputs
//
// Ports
//   clk                 system clock (65 MHz nominal)
//   rst                 asynchronous, active-high reset
//   en                  detection enable; low flushes the pipeline and masks outputs
//   xposball, yposball  ball centre, unsigned px (y grows downward)
//   xpos_p1, ypos_p1    player 1 head centre, unsigned px
//   xpos_p2, ypos_p2    player 2 head centre, unsigned px
//   contact_p1/_p2      registered level: ball currently overlaps player n
//   collisionsplayer1/2 1-cycle pulse: new contact with player n
//   gnd_col             1-cycle pulse: ball reached the ground
// ---------------------------------------------------------------------------
module ball_collision_detect #(
  parameter int unsigned BALL_R     = 16,
  parameter int unsigned PLAYER_R   = 32,
  parameter int unsigned GROUND_POS = 750,
  parameter int unsigned GND_HYST   = 8,
  parameter logic [23:0] HOLDOFF    = 24'd650_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] xposball,
  input  logic [11:0] yposball,
  input  logic [11:0] xpos_p1,
  input  logic [11:0] ypos_p1,
  input  logic [11:0] xpos_p2,
  input  logic [11:0] ypos_p2,
  output logic        contact_p1,
  output logic        contact_p2,
  output logic        collisionsplayer1,
  output logic        collisionsplayer2,
  output logic        gnd_col
);

  localparam int unsigned NUM_P = 2;

  // Squared contact distance; equality counts as a touch.
  localparam logic [26:0] HIT_SQ  = 27'((BALL_R + PLAYER_R) * (BALL_R + PLAYER_R));
  localparam logic [12:0] BALL_RW = 13'(BALL_R);
  localparam logic [12:0] GND_Y   = 13'(GROUND_POS);
  // Ball bottom must come strictly above this line to re-arm the ground pulse.
  localparam logic [12:0] ARM_Y   = 13'(GROUND_POS - GND_HYST);

  // Player coordinates as arrays so the per-player logic is written once.
  logic [11:0] xp [NUM_P];
  logic [11:0] yp [NUM_P];

  assign xp[0] = xpos_p1;
  assign yp[0] = ypos_p1;
  assign xp[1] = xpos_p2;
  assign yp[1] = ypos_p2;

  // -------------------------------------------------------------------------
  // S1: signed deltas and ground compare
  // -------------------------------------------------------------------------
  logic signed [12:0] dx_d [NUM_P];
  logic signed [12:0] dy_d [NUM_P];
  logic        [12:0] ball_bot;
  logic               gnd_hit_d;
  logic               gnd_arm_d;

  // NOTE: every signal written in an always_comb gets a value on every path
  // (here unconditionally) so no latch is inferred.
  always_comb begin
    ball_bot  = {1'b0, yposball} + BALL_RW;
    gnd_hit_d = (ball_bot >= GND_Y);
    gnd_arm_d = (ball_bot <  ARM_Y);
    for (int i = 0; i < NUM_P; i++) begin
      // Zero-extend the unsigned inputs into 13 bits so the difference keeps its sign.
      dx_d[i] = signed'({1'b0, xposball}) - signed'({1'b0, xp[i]});
      dy_d[i] = signed'({1'b0, yposball}) - signed'({1'b0, yp[i]});
    end
  end

  logic               v1;
  logic signed [12:0] dx1 [NUM_P];
  logic signed [12:0] dy1 [NUM_P];
  logic               gnd_hit1;
  logic               gnd_arm1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours and stage order does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1       <= 1'b0;
      gnd_hit1 <= 1'b0;
      gnd_arm1 <= 1'b0;
      for (int i = 0; i < NUM_P; i++) begin
        dx1[i] <= '0;
        dy1[i] <= '0;
      end
    end else begin
      v1       <= en;
      gnd_hit1 <= gnd_hit_d;
      gnd_arm1 <= gnd_arm_d;
      for (int i = 0; i < NUM_P; i++) begin
        dx1[i] <= dx_d[i];
        dy1[i] <= dy_d[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // S2: squared distance, full precision
  // -------------------------------------------------------------------------
  logic signed [25:0] px_d [NUM_P];
  logic signed [25:0] py_d [NUM_P];
  logic        [26:0] sq_d [NUM_P];

  always_comb begin
    for (int i = 0; i < NUM_P; i++) begin
      // Size casts sign-extend the deltas to the full 26-bit product width.
      px_d[i] = 26'(dx1[i]) * 26'(dx1[i]);
      py_d[i] = 26'(dy1[i]) * 26'(dy1[i]);
      // Squares are never negative, so they may be treated as unsigned.
      sq_d[i] = {1'b0, unsigned'(px_d[i])} + {1'b0, unsigned'(py_d[i])};
    end
  end

  logic        v2;
  logic [26:0] sq2 [NUM_P];
  logic        gnd_hit2;
  logic        gnd_arm2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2       <= 1'b0;
      gnd_hit2 <= 1'b0;
      gnd_arm2 <= 1'b0;
      for (int i = 0; i < NUM_P; i++) begin
        sq2[i] <= '0;
      end
    end else begin
      // Dropping en flushes the whole pipeline on the same edge.
      v2       <= en & v1;
      gnd_hit2 <= gnd_hit1;
      gnd_arm2 <= gnd_arm1;
      for (int i = 0; i < NUM_P; i++) begin
        sq2[i] <= sq_d[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // S3: contact compare, edge detect, holdoff, ground arming
  // -------------------------------------------------------------------------
  logic [NUM_P-1:0] hit_d;
  logic [NUM_P-1:0] pulse_d;
  logic             gnd_pulse_d;
  logic             gnd_rearm_d;

  // contact_q doubles as the previous-contact flag for the edge detector.
  logic [NUM_P-1:0] contact_q;
  logic [NUM_P-1:0] pulse_q;
  logic             gnd_q;
  logic             armed_q;
  logic [23:0]      holdoff_q [NUM_P];

  always_comb begin
    for (int i = 0; i < NUM_P; i++) begin
      hit_d[i]   = en & v2 & (sq2[i] <= HIT_SQ);
      // A rising edge seen while the lockout runs is dropped, not deferred.
      pulse_d[i] = hit_d[i] & ~contact_q[i] & (holdoff_q[i] == 24'd0);
    end
    gnd_pulse_d = en & v2 & gnd_hit2 & armed_q;
    gnd_rearm_d = en & v2 & gnd_arm2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contact_q <= '0;
      pulse_q   <= '0;
      gnd_q     <= 1'b0;
      armed_q   <= 1'b1;
      for (int i = 0; i < NUM_P; i++) begin
        holdoff_q[i] <= '0;
      end
    end else begin
      // hit_d/pulse_d already include en, so disabling clears the outputs and
      // the previous-contact flags together.
      contact_q <= hit_d;
      pulse_q   <= pulse_d;
      gnd_q     <= gnd_pulse_d;

      // The ground pulse clears arming; only a clear rise above the hysteresis
      // line re-arms it. Between the two thresholds arming holds.
      if (!en) begin
        armed_q <= 1'b1;
      end else if (gnd_pulse_d) begin
        armed_q <= 1'b0;
      end else if (gnd_rearm_d) begin
        armed_q <= 1'b1;
      end

      // Lockout keeps running while disabled and saturates at zero.
      for (int i = 0; i < NUM_P; i++) begin
        if (pulse_d[i]) begin
          holdoff_q[i] <= HOLDOFF;
        end else if (holdoff_q[i] != 24'd0) begin
          holdoff_q[i] <= holdoff_q[i] - 24'd1;
        end
      end
    end
  end

  assign contact_p1        = contact_q[0];
  assign contact_p2        = contact_q[1];
  assign collisionsplayer1 = pulse_q[0];
  assign collisionsplayer2 = pulse_q[1];
  assign gnd_col           = gnd_q;

endmodule

// File: tb/tb_ball_collision_detect.sv
// ---------------------------------------------------------------------------
// tb_ball_collision_detect
//
// Drives directed contact scenarios followed by a randomized phase. The
// expected outputs come from a reference model that works from the geometry:
// Euclidean distance against the summed radii, ground line with hysteresis,
// and a lockout timer. That model sits beside a 3-sample input history and a
// run length of enabled edges.
// ---------------------------------------------------------------------------
module tb_ball_collision_detect;

  localparam int HOLD       = 200;
  localparam int R_SUM      = 48;
  localparam int GROUND_POS = 750;
  localparam int GND_HYST   = 8;
  localparam int BALL_R     = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [11:0] xposball = '0, yposball = '0;
  logic [11:0] xpos_p1 = '0, ypos_p1 = '0, xpos_p2 = '0, ypos_p2 = '0;
  logic        contact_p1, contact_p2, collisionsplayer1, collisionsplayer2, gnd_col;

  ball_collision_detect #(.HOLDOFF(24'(HOLD))) dut (
    .clk               (clk),
    .rst               (rst),
    .en                (en),
    .xposball          (xposball),
    .yposball          (yposball),
    .xpos_p1           (xpos_p1),
    .ypos_p1           (ypos_p1),
    .xpos_p2           (xpos_p2),
    .ypos_p2           (ypos_p2),
    .contact_p1        (contact_p1),
    .contact_p2        (contact_p2),
    .collisionsplayer1 (collisionsplayer1),
    .collisionsplayer2 (collisionsplayer2),
    .gnd_col           (gnd_col)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Pulse tallies taken from the DUT, used for per-scenario count checks.
  int n_p1 = 0, n_p2 = 0, n_gnd = 0;

  // ---------------- reference model ----------------
  typedef struct {
    int xb, yb, x1, y1, x2, y2;
  } sample_t;

  sample_t hist[$];
  int      run;          // consecutive enabled edges since reset/disable
  bit      m_prev [2];
  int      m_hold [2];
  bit      m_armed;
  bit      e_ct   [2];
  bit      e_pl   [2];
  bit      e_gnd;

  function automatic bit touches(int xb, int yb, int xp, int yp);
    int dx = xb - xp;
    int dy = yb - yp;
    return (dx * dx + dy * dy) <= R_SUM * R_SUM;
  endfunction

  task automatic model_reset();
    hist.delete();
    run     = 0;
    m_armed = 1'b1;
    e_gnd   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = 1'b0;
      m_hold[i] = 0;
      e_ct[i]   = 1'b0;
      e_pl[i]   = 1'b0;
    end
  endtask

  // Called once per clock edge with the inputs that edge sampled.
  task automatic model_step();
    sample_t s;
    bit      valid;
    bit      gh, ga;
    s.xb = int'(xposball); s.yb = int'(yposball);
    s.x1 = int'(xpos_p1);  s.y1 = int'(ypos_p1);
    s.x2 = int'(xpos_p2);  s.y2 = int'(ypos_p2);
    hist.push_back(s);
    if (hist.size() > 3) void'(hist.pop_front());
    run   = en ? run + 1 : 0;
    // Output at this edge reflects the sample taken two edges ago, provided
    // detection stayed enabled across all three edges.
    valid = (run >= 3);
    gh = 1'b0; ga = 1'b0;
    e_ct[0] = 1'b0; e_ct[1] = 1'b0;
    if (valid) begin
      e_ct[0] = touches(hist[0].xb, hist[0].yb, hist[0].x1, hist[0].y1);
      e_ct[1] = touches(hist[0].xb, hist[0].yb, hist[0].x2, hist[0].y2);
      gh = (hist[0].yb + BALL_R >= GROUND_POS);
      ga = (hist[0].yb + BALL_R <  GROUND_POS - GND_HYST);
    end
    for (int i = 0; i < 2; i++) begin
      e_pl[i] = e_ct[i] && !m_prev[i] && (m_hold[i] == 0);
      if (e_pl[i])          m_hold[i] = HOLD;
      else if (m_hold[i] > 0) m_hold[i] = m_hold[i] - 1;
      m_prev[i] = e_ct[i];
    end
    e_gnd = valid && gh && m_armed;
    if (!en)        m_armed = 1'b1;
    else if (e_gnd) m_armed = 1'b0;
    else if (ga)    m_armed = 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample the edge into the model, then compare all outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check("contact_p1", contact_p1, e_ct[0]);
    check("contact_p2", contact_p2, e_ct[1]);
    check("pulse_p1",   collisionsplayer1, e_pl[0]);
    check("pulse_p2",   collisionsplayer2, e_pl[1]);
    check("gnd_col",    gnd_col, e_gnd);
    n_p1  += int'(collisionsplayer1);
    n_p2  += int'(collisionsplayer2);
    n_gnd += int'(gnd_col);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_c1"},  contact_p1, 1'b0);
    check({tag, "_c2"},  contact_p2, 1'b0);
    check({tag, "_p1"},  collisionsplayer1, 1'b0);
    check({tag, "_p2"},  collisionsplayer2, 1'b0);
    check({tag, "_gnd"}, gnd_col, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    n_p1 = 0; n_p2 = 0; n_gnd = 0;
  endtask

  task automatic set_pos(input int xb, input int yb, input int x1, input int y1,
                         input int x2, input int y2);
    xposball = 12'(xb); yposball = 12'(yb);
    xpos_p1  = 12'(x1); ypos_p1  = 12'(y1);
    xpos_p2  = 12'(x2); ypos_p2  = 12'(y2);
  endtask

  initial begin
    model_reset();
    #2;
    check_all_zero("por");

    // 1) single pulse 3 clk after the contact sample, none while held
    do_reset();
    en = 1'b1;
    set_pos(100, 100, 100, 140, 3000, 3000);
    ticks(2);
    check("t1_early_p1", collisionsplayer1, 1'b0);
    tick();
    check("t1_lat_c1", contact_p1, 1'b1);
    check("t1_lat_p1", collisionsplayer1, 1'b1);
    ticks(1000);
    check_int("t1_held_cnt", n_p1, 1);
    check("t1_held_c1", contact_p1, 1'b1);

    // 2) radius boundary: distance 48 touches, 49 does not
    do_reset();
    en = 1'b1;
    set_pos(100, 100, 100, 148, 3000, 3000);
    ticks(3);
    check("t2_d48_c1", contact_p1, 1'b1);
    set_pos(100, 100, 100, 149, 3000, 3000);
    ticks(3);
    check("t2_d49_c1", contact_p1, 1'b0);

    // 3) holdoff: re-contact inside lockout dropped, after lockout pulses
    do_reset();
    en = 1'b1;
    set_pos(100, 100, 100, 140, 3000, 3000);
    ticks(100);
    set_pos(100, 100, 100, 400, 3000, 3000);
    ticks(10);
    set_pos(100, 100, 100, 140, 3000, 3000);
    ticks(20);
    check_int("t3_locked_cnt", n_p1, 1);
    set_pos(100, 100, 100, 400, 3000, 3000);
    ticks(110);
    set_pos(100, 100, 100, 140, 3000, 3000);
    ticks(10);
    check_int("t3_rearm_cnt", n_p1, 2);

    // 4) ground pulse with hysteresis
    do_reset();
    en = 1'b1;
    set_pos(100, 700, 2000, 100, 3000, 100);
    ticks(10);
    yposball = 12'd734;
    ticks(10);
    check_int("t4_first_cnt", n_gnd, 1);
    for (int y = 735; y <= 740; y++) begin
      yposball = 12'(y);
      ticks(3);
    end
    yposball = 12'd730;
    ticks(10);
    check_int("t4_hyst_cnt", n_gnd, 1);
    yposball = 12'd725;
    ticks(10);
    yposball = 12'd734;
    ticks(10);
    check_int("t4_second_cnt", n_gnd, 2);

    // 5) all three events from one sample land on the same clock
    do_reset();
    en = 1'b1;
    set_pos(400, 500, 400, 700, 430, 740);
    ticks(5);
    set_pos(400, 740, 400, 700, 430, 740);
    ticks(2);
    check("t5_early_gnd", gnd_col, 1'b0);
    tick();
    check("t5_p1",  collisionsplayer1, 1'b1);
    check("t5_p2",  collisionsplayer2, 1'b1);
    check("t5_gnd", gnd_col, 1'b1);

    // 6) asynchronous reset while contact is held mid-pipeline
    do_reset();
    en = 1'b1;
    set_pos(100, 100, 100, 140, 3000, 3000);
    ticks(5);
    check("t6_pre_c1", contact_p1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t6_async");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ticks(2);
    check("t6_refill_p1", collisionsplayer1, 1'b0);
    tick();
    check("t6_after_p1", collisionsplayer1, 1'b1);

    // 7) enable masking: overlapping ball pulses 3 clk after en rises
    en = 1'b0;
    ticks(250);
    check("t7_dis_c1", contact_p1, 1'b0);
    en = 1'b1;
    ticks(2);
    check("t7_early_p1", collisionsplayer1, 1'b0);
    tick();
    check("t7_en_p1", collisionsplayer1, 1'b1);

    // 8) randomized: clustered geometry, sticky inputs, occasional full range
    do_reset();
    en = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          set_pos($urandom_range(0, 4095), $urandom_range(0, 4095),
                  $urandom_range(0, 4095), $urandom_range(0, 4095),
                  $urandom_range(0, 4095), $urandom_range(0, 4095));
        end else begin
          set_pos($urandom_range(400, 500), $urandom_range(690, 760),
                  $urandom_range(380, 520), $urandom_range(660, 780),
                  $urandom_range(380, 520), $urandom_range(660, 780));
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
